fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage for the 9-bit-ISA core; successor to the single-cycle PC.
//  Issues PC requests to a 1-cycle-latency instruction ROM and buffers returned words in a
//  DEPTH-entry prefetch queue, each word tagged with its PC. Presents them to the decoder on a
//  valid/ready handshake. Supports absolute redirect with flush and sticky halt with a done flag.
// PARAMETERS
//  IW     8  PC / ROM address width; PC wraps modulo 2**IW
//  INW    9  instruction word width
//  DEPTH  4  prefetch queue entries; power of 2, >=2
// PORTS
//  clk             in   1      clock, all state on rising edge
//  reset           in   1      asynchronous, active-high; clears all state
//  rom_req_o       out  1      ROM read strobe this cycle
//  rom_addr_o      out  IW     ROM address; equals fetch PC
//  rom_data_i      in   INW    ROM word; valid the cycle after rom_req_o
//  instr_valid_o   out  1      queue head valid
//  instr_o         out  INW    queue head instruction
//  instr_pc_o      out  IW     PC of queue head
//  instr_ready_i   in   1      decoder accepts head (pop on valid&&ready)
//  redirect_i      in   1      taken branch: flush, refetch from target
//  redirect_pc_i   in   IW     absolute redirect target
//  halt_i          in   1      halt decoded; sticky until reset
//  done_o          out  1      halted and no ROM read in flight
//  perf_fetch_o    out  16     words pushed (FETCH_PERF_EN only, else 0)
//  perf_flush_o    out  16     redirects taken (FETCH_PERF_EN only, else 0)
// BEHAVIOUR
//  - Reset: fetch_pc=0, queue empty, inflight=0, epoch=0, halted=0; every output 0.
//  - Issue: rom_req_o = !halted && !redirect_i && (count + inflight - pop) < DEPTH;
//    on issue fetch_pc <= fetch_pc+1 (2**IW-1 wraps to 0); inflight <= rom_req_o.
//  - Return: cycle after issue, {rom_data_i, issued PC} pushed if the issue epoch equals the
//    current epoch; otherwise dropped. Latency issue->instr_valid_o = 2 cycles.
//  - Steady throughput 1 instr/cycle with instr_ready_i held high, any DEPTH>=2.
//  - Full: no issue, so no push into a full queue. Empty: instr_valid_o=0; instr_o/instr_pc_o
//    hold the last head value.
//  - Redirect (1-cycle pulse): that cycle's pop completes (it is the branch); queue cleared;
//    epoch toggles (kills the in-flight return); fetch_pc <= redirect_pc_i; no issue that cycle.
//    First target request next cycle, target valid 2 cycles later. Redirect beats push.
//  - Halt: halted <= 1; issue stops the same cycle; queue keeps draining to decoder.
//    done_o = halted && !inflight (registered, high 1 cycle after last return).
//    redirect_i while halted: ignored.
//  - Reset mid-operation: immediate clear; an in-flight ROM word never enters the queue.
// CONFIGURATION
//  FETCH_PERF_EN defined: two 16-bit saturating counters. perf_fetch_o +1 per accepted push;
//    perf_flush_o +1 per honoured redirect; both cleared by reset.
//  FETCH_PERF_EN undefined: no counter flops; perf_* ports tied to 0.
// STRUCTURE
//  cpu_pkg: instr_t (logic [INW-1:0]), pc_t (logic [IW-1:0]), fetch_entry_t {instr_t, pc_t}.
//  Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t, push/pop/flush,
//    count output. fetch_unit holds PC, epoch, inflight, halt and issue logic.
// TESTING
//  1 Reset, ready=1, ROM[i]=i: first req at 0; instr_valid_o high on cycle 2;
//    PCs 0,1,2,.. one per cycle.
//  2 ready=0, DEPTH=4: exactly 4 entries fill (PC 0-3), rom_req_o low; ready=1 drains
//    in order, issue resumes at PC 4.
//  3 redirect_i to 0x40 while PC 5 in flight: PC 5 never presented; next valid instr_pc_o=0x40.
//  4 fetch_pc=0xFF (IW=8): word at 0xFF then 0x00, no gap.
//  5 halt_i with 2 queued + 1 in flight: all 3 delivered; done_o high 1 cycle after return;
//    later redirect_i ignored.
//  6 FETCH_PERF_EN: 10 pushes, 2 redirects -> perf_fetch_o=10, perf_flush_o=2;
//    without it both read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the 9-bit-ISA core front end.
// fetch_entry_t is one prefetch queue slot: the returned ROM word tagged with
// the PC it was fetched from.
package cpu_pkg;

    localparam int CPU_IW  = 8;
    localparam int CPU_INW = 9;

    typedef logic [CPU_INW-1:0] instr_t;
    typedef logic [CPU_IW-1:0]  pc_t;

    typedef struct packed {
        instr_t instr;
        pc_t    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous DEPTH-entry FIFO with push, pop and flush.
// Flush wins over push and pop in the same cycle. When empty, head_o keeps
// showing the last head value instead of a stale storage slot.
module fetch_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  last_q;
    logic          do_push;
    logic          do_pop;

    // Pointer and occupancy next-state; flush clears everything.
    always_comb begin
        do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
        do_pop  = pop_i && !flush_i && (count_q != '0);
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control state and the held head value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            last_q  <= head_o;
        end
    end

    // Entry storage; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_q] : last_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues PC reads to a 1-cycle-latency ROM and
// buffers returned words, tagged with their PC, in a prefetch queue that
// feeds the decoder over valid/ready. Redirect flushes and refetches;
// an epoch bit discards the ROM word that was in flight at the redirect.
// Halt is sticky; done_o rises once no ROM read is outstanding.
// Optional macro FETCH_PERF_EN adds 16-bit saturating push/redirect counters;
// without it perf_fetch_o/perf_flush_o are tied to zero.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int IW    = CPU_IW,
    parameter int INW   = CPU_INW,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    output logic           rom_req_o,
    output logic [IW-1:0]  rom_addr_o,
    input  logic [INW-1:0] rom_data_i,
    output logic           instr_valid_o,
    output logic [INW-1:0] instr_o,
    output logic [IW-1:0]  instr_pc_o,
    input  logic           instr_ready_i,
    input  logic           redirect_i,
    input  logic [IW-1:0]  redirect_pc_i,
    input  logic           halt_i,
    output logic           done_o,
    output logic [15:0]    perf_fetch_o,
    output logic [15:0]    perf_flush_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [IW-1:0] fetch_pc_q, fetch_pc_d;
    logic [IW-1:0] issue_pc_q, issue_pc_d;
    logic          issue_epoch_q, issue_epoch_d;
    logic          epoch_q, epoch_d;
    logic          inflight_q, inflight_d;
    logic          halted_q, halted_d;
    logic          done_q, done_d;

    logic [CW-1:0]       fifo_count;
    logic [IW+INW-1:0]   fifo_head;
    logic [OW-1:0]       occ;
    logic                pop;
    logic                push;
    logic                redir_take;
    logic                issue;

    assign instr_valid_o = (fifo_count != '0);
    assign pop           = instr_valid_o && instr_ready_i;
    assign redir_take    = redirect_i && !halted_q;

    // Slots already claimed once this cycle's pop leaves; pop implies count>=1.
    assign occ   = OW'(fifo_count) + OW'(inflight_q) - OW'(pop);
    assign issue = !reset && !halted_q && !halt_i && !redirect_i && (occ < OW'(DEPTH));

    // A return is kept only if issued in the current epoch; redirect beats push.
    assign push = inflight_q && (issue_epoch_q == epoch_q) && !redir_take;

    // Next-state for PC, epoch, in-flight tracking, halt and done.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        issue_pc_d    = issue_pc_q;
        issue_epoch_d = issue_epoch_q;
        epoch_d       = epoch_q ^ redir_take;
        inflight_d    = issue;
        halted_d      = halted_q || halt_i;
        if (redir_take) begin
            fetch_pc_d = redirect_pc_i;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
        end
        if (issue) begin
            issue_pc_d    = fetch_pc_q;
            issue_epoch_d = epoch_q;
        end
        done_d = halted_d && !inflight_d;
    end

    // Fetch control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            issue_pc_q    <= '0;
            issue_epoch_q <= 1'b0;
            epoch_q       <= 1'b0;
            inflight_q    <= 1'b0;
            halted_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            issue_pc_q    <= issue_pc_d;
            issue_epoch_q <= issue_epoch_d;
            epoch_q       <= epoch_d;
            inflight_q    <= inflight_d;
            halted_q      <= halted_d;
            done_q        <= done_d;
        end
    end

    fetch_fifo #(
        .W     (IW + INW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  ({rom_data_i, issue_pc_q}),
        .pop_i   (pop),
        .flush_i (redir_take),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign rom_req_o  = issue;
    assign rom_addr_o = fetch_pc_q;
    assign instr_o    = fifo_head[IW+INW-1:IW];
    assign instr_pc_o = fifo_head[IW-1:0];
    assign done_o     = done_q;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_q;
    logic [15:0] perf_flush_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating event counters for accepted pushes and honoured redirects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (push)       perf_fetch_q <= sat_inc(perf_fetch_q);
            if (redir_take) perf_flush_q <= sat_inc(perf_flush_q);
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_flush_o = perf_flush_q;
`else
    assign perf_fetch_o = '0;
    assign perf_flush_o = '0;
`endif

endmodule
